audio_i2s_out: RTL

- Downstream output stage for the PSG.
- Mixes the PSG stereo samples with a 16-bit PCM stereo stream, saturates the result to 24 bits, and serialises it as a standard I2S frame (BCK, LRCK, DATA) for the external DAC.
- Sole source of the sample-rate strobe: pulses next_sample to the PSG and pcm_next to the PCM source once per frame.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_sat_mix.sv | 26 ++
 rtl/audio_i2s_out.sv | 108 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared widths, shift amounts and saturation limits for the PSG/PCM audio output path.
package audio_pkg;
  localparam int PSG_W             = 19;
  localparam int PCM_W             = 16;
  localparam int SAMPLE_W          = 24;
  localparam int SLOT_BITS_DEFAULT = 32;
  localparam int PSG_SHIFT         = 3;
  localparam int PCM_SHIFT         = 8;
  // One guard bit above the output sample so the sum never wraps before saturation.
  localparam int MIX_W             = SAMPLE_W + 1;

  localparam logic signed [MIX_W-1:0] SAT_MAX = 25'sd8388607;
  localparam logic signed [MIX_W-1:0] SAT_MIN = -25'sd8388608;
endpackage

// File: rtl/audio_sat_mix.sv
// Combinational mixer: scales PSG and PCM into a common 25-bit range, adds, saturates to 24 bits.
module audio_sat_mix
  import audio_pkg::*;
(
  input  logic [PSG_W-1:0]    psg,
  input  logic [PCM_W-1:0]    pcm,
  output logic [SAMPLE_W-1:0] sample
);
  logic signed [MIX_W-1:0] psg_ext;
  logic signed [MIX_W-1:0] pcm_ext;
  logic signed [MIX_W-1:0] mix_sum;

  assign psg_ext = {{(MIX_W-PSG_W){psg[PSG_W-1]}}, psg};
  assign pcm_ext = {{(MIX_W-PCM_W){pcm[PCM_W-1]}}, pcm};
  assign mix_sum = (psg_ext <<< PSG_SHIFT) + (pcm_ext <<< PCM_SHIFT);

  always_comb begin
    if (mix_sum > SAT_MAX) begin
      sample = SAT_MAX[SAMPLE_W-1:0];
    end else if (mix_sum < SAT_MIN) begin
      sample = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sample = mix_sum[SAMPLE_W-1:0];
    end
  end
endmodule

// File: rtl/audio_i2s_out.sv
// I2S transmitter: mixes PSG and PCM per channel, holds one frame's samples and serialises them
// MSB first with a one-BCK delay; it is also the sample-rate strobe source for both producers.
module audio_i2s_out
  import audio_pkg::*;
#(
  parameter int CLK_PER_HALF_BCK = 4,
  parameter int SLOT_BITS        = SLOT_BITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PSG_W-1:0] psg_left,
  input  logic [PSG_W-1:0] psg_right,
  input  logic [PCM_W-1:0] pcm_left,
  input  logic [PCM_W-1:0] pcm_right,
  output logic             next_sample,
  output logic             pcm_next,
  output logic             i2s_bck,
  output logic             i2s_lrck,
  output logic             i2s_data
);
  localparam int HALF_W = $clog2(4 * SLOT_BITS);
  localparam int DIV_W  = (CLK_PER_HALF_BCK > 1) ? $clog2(CLK_PER_HALF_BCK) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_PER_HALF_BCK - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(4 * SLOT_BITS - 1);
  localparam logic [HALF_W-2:0] SLOT_CNT  = (HALF_W-1)'(SLOT_BITS);
  localparam logic [HALF_W-2:0] LAST_DATA = (HALF_W-1)'(SAMPLE_W);

  logic [DIV_W-1:0]             div_cnt_reg, div_cnt_next;
  logic [HALF_W-1:0]            half_cnt_reg, half_cnt_next;
  logic [1:0][SAMPLE_W-1:0]     hold_reg;
  logic [1:0][SAMPLE_W-1:0]     mix;
  logic [1:0][PSG_W-1:0]        psg_ch;
  logic [1:0][PCM_W-1:0]        pcm_ch;
  logic [HALF_W-2:0]            bit_idx_next, slot_next;
  logic [SAMPLE_W-1:0]          word_next;
  logic                         chan_next, data_next, div_wrap, frame_end;
  logic                         bck_reg, lrck_reg, data_reg;

  assign psg_ch = {psg_right, psg_left};
  assign pcm_ch = {pcm_right, pcm_left};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mix
      audio_sat_mix u_mix (
        .psg    (psg_ch[gi]),
        .pcm    (pcm_ch[gi]),
        .sample (mix[gi])
      );
    end
  endgenerate

  assign div_wrap    = (div_cnt_reg == DIV_LAST);
  assign frame_end   = enable && !rst && div_wrap && (half_cnt_reg == HALF_LAST);
  assign next_sample = frame_end;
  assign pcm_next    = frame_end;

  always_comb begin
    div_cnt_next  = '0;
    half_cnt_next = '0;
    if (enable) begin
      if (div_wrap) begin
        half_cnt_next = (half_cnt_reg == HALF_LAST) ? '0 : half_cnt_reg + 1'b1;
      end else begin
        div_cnt_next  = div_cnt_reg + 1'b1;
        half_cnt_next = half_cnt_reg;
      end
    end
  end

  // Data is derived from the upcoming bit index, which only moves when BCK falls,
  // so i2s_data cannot change while BCK is high.
  always_comb begin
    bit_idx_next = half_cnt_next[HALF_W-1:1];
    chan_next    = (bit_idx_next >= SLOT_CNT);
    slot_next    = chan_next ? bit_idx_next - SLOT_CNT : bit_idx_next;
    word_next    = hold_reg[chan_next] >> (HALF_W'(SAMPLE_W) - HALF_W'(slot_next));
    data_next    = 1'b0;
    if (enable && (slot_next != '0) && (slot_next <= LAST_DATA)) begin
      data_next = word_next[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg  <= '0;
      half_cnt_reg <= '0;
      hold_reg     <= '0;
      bck_reg      <= 1'b0;
      lrck_reg     <= 1'b0;
      data_reg     <= 1'b0;
    end else begin
      div_cnt_reg  <= div_cnt_next;
      half_cnt_reg <= half_cnt_next;
      bck_reg      <= half_cnt_next[0];
      lrck_reg     <= chan_next;
      data_reg     <= data_next;
      if (frame_end) begin
        hold_reg <= mix;
      end
    end
  end

  assign i2s_bck  = bck_reg;
  assign i2s_lrck = lrck_reg;
  assign i2s_data = data_reg;
endmodule
